// File: rtl/counter_bank_snapshot.sv
// counter_bank_snapshot: N_CH mode-configurable counters, a registered
// input+1 path, and a one-shot snapshot FSM that streams all channels out.
//
// Ports:
//   clk, reset (async, active-low)
//   primary_input / primary_output : registered primary_input + 1
//   cnt_en[N_CH]                   : per-channel count enable
//   cfg_we, cfg_ch, cfg_mode,
//   cfg_data                       : channel load of value and mode
//   overflow[N_CH]                 : sticky wrap / limit flag
//   snap_req, snap_busy            : snapshot trigger and FSM-busy flag
//   rd_valid, rd_ready, rd_ch,
//   rd_data                        : snapshot beat stream
//
// Build option: define COUNTER_BANK_SATURATE_EN to make increment and
// decrement stop at their limits instead of wrapping.

module counter_bank_snapshot #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int IN_W  = 8,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   primary_input,
    output logic [IN_W-1:0]   primary_output,
    input  logic [N_CH-1:0]   cnt_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic [N_CH-1:0]   overflow,
    input  logic              snap_req,
    output logic              snap_busy,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_data
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;
    localparam logic [1:0] MODE_TOG  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(N_CH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [1:0]       mode_q [N_CH];
    logic [1:0]       mode_d [N_CH];
    logic [CNT_W-1:0] snap_q [N_CH];
    logic [CNT_W-1:0] snap_d [N_CH];

    logic [N_CH-1:0]  ovf_q;
    logic [N_CH-1:0]  ovf_d;
    logic [IN_W-1:0]  pout_q;
    logic [IN_W-1:0]  pout_d;

    state_t           state_q;
    state_t           state_d;
    logic             busy_q;
    logic             busy_d;
    logic             rd_valid_q;
    logic             rd_valid_d;
    logic [CH_W-1:0]  rd_ch_q;
    logic [CH_W-1:0]  rd_ch_d;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_data_d;

    logic             cfg_ok;
    logic [N_CH-1:0]  cfg_hit;
    logic             beat_xfer;
    logic             rd_last;
    logic [CH_W-1:0]  rd_nxt;

    // ------------------------------------------------------------------
    // Configuration decode: out-of-range channels hit nothing.
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ok = ({1'b0, cfg_ch} < CH_LIMIT);
        for (int i = 0; i < N_CH; i++) begin
            cfg_hit[i] = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Counter channels. A write to a channel wins over its count enable.
    // ------------------------------------------------------------------
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            mode_d[i] = mode_q[i];
            if (cfg_hit[i]) begin
                cnt_d[i]  = cfg_data;
                mode_d[i] = cfg_mode;
                ovf_d[i]  = 1'b0;
            end else if (cnt_en[i]) begin
                unique case (mode_q[i])
                    MODE_HOLD: begin
                        cnt_d[i] = cnt_q[i];
                    end
                    MODE_INC: begin
                        if (cnt_q[i] == CNT_MAX) begin
                            ovf_d[i] = 1'b1;
                        end
`ifdef COUNTER_BANK_SATURATE_EN
                        if (cnt_q[i] != CNT_MAX) begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
`else
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
`endif
                    end
                    MODE_DEC: begin
                        if (cnt_q[i] == CNT_ZERO) begin
                            ovf_d[i] = 1'b1;
                        end
`ifdef COUNTER_BANK_SATURATE_EN
                        if (cnt_q[i] != CNT_ZERO) begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
`else
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
`endif
                    end
                    MODE_TOG: begin
                        cnt_d[i] = cnt_q[i] ^ CNT_ONE;
                    end
                    default: begin
                        cnt_d[i] = cnt_q[i];
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    always_comb begin
        pout_d = primary_input + IN_W'(1);
    end

    // ------------------------------------------------------------------
    // Snapshot FSM. Capture takes the pre-update counter values; the
    // next beat's data is preloaded so rd_data is always a flop output.
    // ------------------------------------------------------------------
    always_comb begin
        beat_xfer = rd_valid_q && rd_ready;
        rd_last   = (rd_ch_q == CH_LAST);
        rd_nxt    = rd_ch_q + CH_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        rd_valid_d = rd_valid_q;
        rd_ch_d    = rd_ch_q;
        rd_data_d  = rd_data_q;
        for (int i = 0; i < N_CH; i++) begin
            snap_d[i] = snap_q[i];
        end
        unique case (state_q)
            IDLE: begin
                if (snap_req) begin
                    for (int i = 0; i < N_CH; i++) begin
                        snap_d[i] = cnt_q[i];
                    end
                    state_d    = STREAM;
                    busy_d     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_ch_d    = '0;
                    rd_data_d  = cnt_q[0];
                end
            end
            STREAM: begin
                if (beat_xfer) begin
                    if (rd_last) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        rd_valid_d = 1'b0;
                    end else begin
                        rd_ch_d    = rd_nxt;
                        rd_data_d  = snap_q[rd_nxt];
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                mode_q[i] <= MODE_HOLD;
                snap_q[i] <= '0;
            end
            ovf_q      <= '0;
            pout_q     <= '0;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                mode_q[i] <= mode_d[i];
                snap_q[i] <= snap_d[i];
            end
            ovf_q      <= ovf_d;
            pout_q     <= pout_d;
            state_q    <= state_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_ch_q    <= rd_ch_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign primary_output = pout_q;
    assign overflow       = ovf_q;
    assign snap_busy      = busy_q;
    assign rd_valid       = rd_valid_q;
    assign rd_ch          = rd_ch_q;
    assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_counter_bank_snapshot.sv
// tb_counter_bank_snapshot: table vectors, directed snapshot sequences
// and a randomized phase against a queue-based reference model.

module tb_counter_bank_snapshot;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 8;
    localparam int CW = 2;
    localparam int MAXV = 65535;
`ifdef COUNTER_BANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [IW-1:0] primary_input = '0;
    logic [IW-1:0] primary_output;
    logic [N-1:0]  cnt_en = '0;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [W-1:0]  cfg_data = '0;
    logic [N-1:0]  overflow;
    logic          snap_req = 1'b0;
    logic          snap_busy;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [CW-1:0] rd_ch;
    logic [W-1:0]  rd_data;

    counter_bank_snapshot #(
        .N_CH (N),
        .CNT_W(W),
        .IN_W (IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .primary_input (primary_input),
        .primary_output(primary_output),
        .cnt_en        (cnt_en),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_mode      (cfg_mode),
        .cfg_data      (cfg_data),
        .overflow      (overflow),
        .snap_req      (snap_req),
        .snap_busy     (snap_busy),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_ch         (rd_ch),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: counters as plain integers, the snapshot stream
    // as a queue of pending beats.
    int m_cnt [N];
    int m_mode[N];
    int m_ovf [N];
    int m_pout;
    int m_q[$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_mode[i] = 0;
            m_ovf[i] = 0;
        end
        m_pout = 0;
        m_q.delete();
    endfunction

    task automatic tick();
        int nc[N];
        int nm[N];
        int no[N];
        for (int i = 0; i < N; i++) begin
            nc[i] = m_cnt[i];
            nm[i] = m_mode[i];
            no[i] = m_ovf[i];
            if (cfg_we && int'(cfg_ch) == i) begin
                nc[i] = int'(cfg_data);
                nm[i] = int'(cfg_mode);
                no[i] = 0;
            end else if (cnt_en[i]) begin
                case (m_mode[i])
                    1: begin
                        if (m_cnt[i] == MAXV) no[i] = 1;
                        if (SAT && m_cnt[i] == MAXV) nc[i] = MAXV;
                        else nc[i] = (m_cnt[i] + 1) % (MAXV + 1);
                    end
                    2: begin
                        if (m_cnt[i] == 0) no[i] = 1;
                        if (SAT && m_cnt[i] == 0) nc[i] = 0;
                        else nc[i] = (m_cnt[i] + MAXV) % (MAXV + 1);
                    end
                    3: nc[i] = m_cnt[i] ^ 1;
                    default: nc[i] = m_cnt[i];
                endcase
            end
        end
        if (m_q.size() == 0) begin
            if (snap_req) begin
                for (int i = 0; i < N; i++) m_q.push_back(m_cnt[i]);
            end
        end else if (rd_ready) begin
            void'(m_q.pop_front());
        end
        m_pout = (int'(primary_input) + 1) % 256;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = nc[i];
            m_mode[i] = nm[i];
            m_ovf[i] = no[i];
        end
    endtask

    function automatic void check_model();
        logic [N-1:0] eo;
        for (int i = 0; i < N; i++) eo[i] = (m_ovf[i] != 0);
        chk("rnd_pout", primary_output, m_pout);
        chk("rnd_ovf", overflow, eo);
        chk("rnd_busy", snap_busy, m_q.size() != 0);
        chk("rnd_valid", rd_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("rnd_rd_ch", rd_ch, N - m_q.size());
            chk("rnd_rd_data", rd_data, m_q[0]);
        end
    endfunction

    logic [W-1:0] sv[N];
    int           snap_beats;

    task automatic snap_read();
        for (int i = 0; i < N; i++) sv[i] = 'x;
        snap_beats = 0;
        cnt_en = '0;
        cfg_we = 1'b0;
        rd_ready = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        for (int c = 0; c < 20 && rd_valid; c++) begin
            chk("snap_order", rd_ch, snap_beats[CW-1:0]);
            sv[rd_ch] = rd_data;
            snap_beats++;
            tick();
        end
        chk("snap_beats", snap_beats, N);
    endtask

    task automatic cfg_write(int ch, int mode, int data);
        cfg_we = 1'b1;
        cfg_ch = CW'(ch);
        cfg_mode = 2'(mode);
        cfg_data = W'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    typedef struct {
        logic [IW-1:0] pin;
        logic [IW-1:0] pout;
    } io_vec_t;

    typedef struct {
        int ch;
        int mode;
        int data;
        int n;
        int exp_v;
        int exp_o;
    } cnt_vec_t;

    io_vec_t  iov[4];
    cnt_vec_t cv[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iov[0] = '{8'hFF, 8'h00};
        iov[1] = '{8'h00, 8'h01};
        iov[2] = '{8'h7F, 8'h80};
        iov[3] = '{8'hFE, 8'hFF};

        cv[0] = '{1, 1, 'hFFFE, 1, 'hFFFF, 0};
        cv[1] = '{1, 1, 'hFFFE, 2, SAT ? 'hFFFF : 'h0000, 1};
        cv[2] = '{1, 1, 'hFFFE, 3, SAT ? 'hFFFF : 'h0001, 1};
        cv[3] = '{0, 2, 'h0001, 2, SAT ? 'h0000 : 'hFFFF, 1};
        cv[4] = '{2, 3, 'h1234, 3, 'h1235, 0};
        cv[5] = '{3, 0, 'hABCD, 5, 'hABCD, 0};
        cv[6] = '{0, 2, 'h0010, 4, 'h000C, 0};
        cv[7] = '{3, 3, 'h00FF, 2, 'h00FF, 0};

        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_low", rd_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_pout", primary_output, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", snap_busy, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_rd_ch", rd_ch, 0);
        chk("rst_rd_data", rd_data, 0);

        for (int k = 0; k < 4; k++) begin
            primary_input = iov[k].pin;
            tick();
            chk("io_vec", primary_output, iov[k].pout);
        end

        for (int k = 0; k < 8; k++) begin
            cfg_write(cv[k].ch, cv[k].mode, cv[k].data);
            cnt_en = '0;
            cnt_en[cv[k].ch] = 1'b1;
            repeat (cv[k].n) tick();
            cnt_en = '0;
            chk("cnt_vec_ovf", overflow[cv[k].ch], cv[k].exp_o[0]);
            snap_read();
            chk("cnt_vec_val", sv[cv[k].ch], cv[k].exp_v);
        end

        // Write and count on the same channel: the write wins.
        cfg_write(2, 1, 'hFFFF);
        cnt_en = 4'b0100;
        tick();
        chk("coll_ovf_set", overflow[2], 1);
        cfg_we = 1'b1;
        cfg_ch = 2'd2;
        cfg_mode = 2'b01;
        cfg_data = 16'h0005;
        tick();
        cfg_we = 1'b0;
        cnt_en = '0;
        chk("coll_ovf_clr", overflow[2], 0);
        snap_read();
        chk("coll_val", sv[2], 16'h0005);

        // Straight four-beat stream.
        for (int i = 0; i < N; i++) cfg_write(i, 0, (i + 1) * 16);
        rd_ready = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        for (int b = 0; b < N; b++) begin
            chk("str_valid", rd_valid, 1);
            chk("str_busy", snap_busy, 1);
            chk("str_ch", rd_ch, b);
            chk("str_data", rd_data, (b + 1) * 16);
            tick();
        end
        chk("str_done_busy", snap_busy, 0);
        chk("str_done_valid", rd_valid, 0);

        // Back-to-back request, stall on beat 1, ignored mid-stream request.
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("b2b_valid", rd_valid, 1);
        tick();
        chk("stall_pre_ch", rd_ch, 1);
        rd_ready = 1'b0;
        snap_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            snap_req = 1'b0;
            chk("stall_ch", rd_ch, 1);
            chk("stall_data", rd_data, 16'h0020);
            chk("stall_valid", rd_valid, 1);
        end
        rd_ready = 1'b1;
        snap_beats = 1;
        for (int c = 0; c < 20 && rd_valid; c++) begin
            chk("stall_order", rd_ch, snap_beats[CW-1:0]);
            snap_beats++;
            tick();
        end
        chk("stall_total", snap_beats, N);
        repeat (2) tick();
        chk("no_queue_busy", snap_busy, 0);

        // Reset while beat 2 is on the port.
        cfg_write(0, 1, 'h0077);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        repeat (2) tick();
        chk("mid_pre_ch", rd_ch, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_valid", rd_valid, 0);
        chk("mid_busy", snap_busy, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_rd_data", rd_data, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tick();
        chk("mid_idle", snap_busy, 0);
        snap_read();
        for (int i = 0; i < N; i++) chk("mid_cnt_zero", sv[i], 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            primary_input = IW'($urandom);
            cnt_en = N'($urandom);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_ch = CW'($urandom_range(0, N - 1));
            cfg_mode = 2'($urandom);
            case ($urandom_range(0, 4))
                0: cfg_data = 16'h0000;
                1: cfg_data = 16'h0001;
                2: cfg_data = 16'hFFFE;
                3: cfg_data = 16'hFFFF;
                default: cfg_data = W'($urandom);
            endcase
            snap_req = ($urandom_range(0, 7) == 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            tick();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_bank_snapshot.md
# counter_bank_snapshot

Parametrised counter bank in the variable-ordering regression suite that generalises fixed 1/16/32/64-bit free-running counters into `N_CH` configurable channels with a per-channel mode, plus a registered input-plus-one path. A one-shot snapshot FSM copies all channels into an unpacked snapshot array and streams the entries out over a valid/ready port. The block is a DUT-style regression target: it mixes packed vectors, unpacked arrays, per-channel state and an FSM in one clock domain.

## Interface
- `N_CH`, default 4, number of counter channels (2..16).
- `CNT_W`, default 16, counter width in bits (1..64).
- `IN_W`, default 8, width of the `primary_input` and `primary_output` path.
- `CH_W`, default `$clog2(N_CH)`, channel index width (derived; do not override).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `primary_input`  in  `IN_W`  data operand.
- `primary_output`  out  `IN_W`  registered `primary_input + 1`.
- `cnt_en`  in  `N_CH`  per-channel count enable.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_ch`  in  `CH_W`  channel targeted by the configuration write.
- `cfg_mode`  in  2  mode: 00 hold, 01 increment, 10 decrement, 11 toggle LSB.
- `cfg_data`  in  `CNT_W`  counter load value.
- `overflow`  out  `N_CH`  sticky per-channel wrap flag.
- `snap_req`  in  1  snapshot request (single-cycle pulse or level).
- `snap_busy`  out  1  high while the FSM is not IDLE.
- `rd_valid`  out  1  snapshot beat valid.
- `rd_ready`  in  1  consumer ready.
- `rd_ch`  out  `CH_W`  channel index of the current beat.
- `rd_data`  out  `CNT_W`  snapshot value of the current beat.

## Operation
- Reset (`reset`=0) clears, asynchronously:
  - all counters, modes, snapshot array entries, `overflow`, `primary_output`, `rd_ch` and `rd_data` to 0;
  - `rd_valid` and `snap_busy` to 0;
  - the FSM to IDLE.
- Configuration write (`cfg_we`=1):
  - channel `cfg_ch` loads `cfg_data` and `cfg_mode`, and its `overflow` bit clears;
  - `cfg_ch` ≥ `N_CH` is ignored entirely.
- Counting: when `cnt_en[i]`=1 and no write targets channel i, the channel updates by its mode.
  - Increment and decrement wrap modulo 2^`CNT_W`.
  - Toggle inverts bit 0 only.
  - Hold leaves the value unchanged.
- Overflow: the `overflow[i]` bit sets on an increment from all-ones or a decrement from 0. It stays set until reset or a write to channel i.
- Collision: when a write and `cnt_en` hit the same channel in the same cycle, the write wins and no count occurs.
- Input path: `primary_output <= primary_input + 1` every cycle, truncated to `IN_W` (0xFF → 0x00 at `IN_W`=8).
- FSM states: IDLE and STREAM.
  - IDLE → STREAM on `snap_req`=1. The clock edge copies all `N_CH` pre-update counter values into the snapshot array and sets `rd_ch`=0.
  - STREAM: `rd_valid`=1 and `rd_data` = snapshot[`rd_ch`].
  - A beat transfers when `rd_valid` and `rd_ready` are both 1 at a clock edge; `rd_ch` then advances.
  - The transfer of beat `N_CH`-1 returns the FSM to IDLE.
- `snap_req` while in STREAM is ignored and is not queued.
- Counters keep running and accept writes during STREAM; the snapshot array is frozen until the next capture.

## Timing
- Counter, `overflow` and `primary_output` update: 1-cycle latency.
- Snapshot:
  - `snap_req` is sampled at edge E; `rd_valid` is high from E, with beat 0 visible in the cycle after E.
  - Minimum stream length is `N_CH` cycles with `rd_ready` held high.
  - The next `snap_req` can be accepted one cycle after the final transfer.
- Stall: while `rd_valid`=1 and `rd_ready`=0, `rd_ch` and `rd_data` hold stable.
- `snap_busy` = (state ≠ IDLE), driven from a register.
- Reset mid-stream: `rd_valid` falls immediately (asynchronously); the beat is abandoned; the FSM comes out of reset in IDLE.

## Configuration
- `COUNTER_BANK_SATURATE_EN`
  - Defined: increment stops at all-ones and decrement stops at 0. `overflow[i]` still sets on any attempt to move past the limit.
  - Undefined: increment and decrement wrap as described in Operation.
  - Toggle, hold and the snapshot path are identical in both builds.

## Test plan
- Reset, then release: all outputs are 0. Drive `primary_input`=0xFF → `primary_output`=0x00 one cycle later.
- Write ch1 with `cfg_data`=0xFFFE and mode 01, hold `cnt_en[1]`=1 for 3 cycles → values 0xFFFF, 0x0000, 0x0001; `overflow[1]`=1 from the wrap cycle. With the macro defined → values 0xFFFF, 0xFFFF, 0xFFFF; `overflow[1]`=1.
- Same-cycle write to ch2 (`cfg_data`=0x0005) with `cnt_en[2]`=1 in mode 01 → ch2=0x0005 and `overflow[2]` cleared.
- Load ch0..3 with 0x10, 0x20, 0x30, 0x40, pulse `snap_req` with `rd_ready`=1 → 4 beats with `rd_ch` 0..3 and `rd_data` 0x10..0x40 on consecutive cycles; `snap_busy` drops after the last beat.
- During a stream: set `rd_ready`=0 for 3 cycles on beat 1 → beat 1 is held unchanged. Pulse `snap_req` mid-stream → it is ignored; exactly 4 beats are delivered in total.
- Assert `reset`=0 during beat 2 → `rd_valid`=0 at once, counters are 0, and the FSM is in IDLE after release.
